// File: rtl/lvds_tx_serializer_pkg.sv
// Shared types and constants for the LVDS transmit serializer.
// Holds the state encoding, default fill/training words and counter sizing.
package lvds_tx_pkg;

  typedef enum logic [0:0] {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } tx_state_e;

  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hF0;
  localparam logic [7:0] IDLE_PATTERN_DEF  = 8'hBC;

  // Counter width for a range of n values; never below one bit so that
  // degenerate builds (e.g. no training) still elaborate cleanly.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lvds_tx_serializer_if.sv
// Upstream word handshake into the serializer (data, valid/ready, enable).
interface lvds_tx_if #(
  parameter int WIDTH = 8
);
  logic             tx_en;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output tx_en, din, din_valid, input  din_ready);
  modport slave  (input  tx_en, din, din_valid, output din_ready);
endinterface

// File: rtl/lvds_tx_serializer_piso.sv
// Shift register, bit counter and frame marker for the serializer.
// Loads next_word on the boundary edge, otherwise shifts MSB-first.
module lvds_tx_piso #(
  parameter int WIDTH = 8,
  parameter int BW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] next_word,
  output logic             boundary,
  output logic             dout,
  output logic             frame
);
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;

  // Counter parks at WIDTH-1 in reset so the first live edge is a load.
  assign boundary = (bitcnt == BW'(WIDTH-1));
  assign dout     = shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= BW'(WIDTH-1);
      frame  <= 1'b0;
    end else if (boundary) begin
      shreg  <= next_word;
      bitcnt <= '0;
      frame  <= 1'b1;
    end else begin
      shreg  <= {shreg[WIDTH-2:0], 1'b0};
      bitcnt <= bitcnt + BW'(1);
      frame  <= 1'b0;
    end
  end
endmodule

// File: rtl/lvds_tx_serializer.sv
// LVDS transmit serializer top: training after reset, then data or idle
// fill selected at each word boundary, with underrun flagging.
module lvds_tx_serializer
  import lvds_tx_pkg::*;
#(
  parameter int                 WIDTH         = 8,
  parameter int                 TRAIN_WORDS   = 4,
  parameter logic [WIDTH-1:0]   TRAIN_PATTERN = WIDTH'(TRAIN_PATTERN_DEF),
  parameter logic [WIDTH-1:0]   IDLE_PATTERN  = WIDTH'(IDLE_PATTERN_DEF)
) (
  input  logic     clk,
  input  logic     rst,
  lvds_tx_if.slave up,
  output logic     dout,
  output logic     frame,
  output logic     underrun,
  output logic     training
);
  localparam int BW = cnt_w(WIDTH);
  localparam int WC = cnt_w(TRAIN_WORDS + 1);

  localparam logic [0:0] S_TRAIN = TRAIN;
  localparam logic [0:0] S_RUN   = RUN;
  localparam logic [0:0] S_RESET = (TRAIN_WORDS == 0) ? S_RUN : S_TRAIN;

  logic [0:0]       state;
  logic [WC-1:0]    wordcnt;
  logic [WC-1:0]    wordcnt_nx;
  logic             boundary;
  logic             run_st;
  logic [WIDTH-1:0] next_word;

  assign run_st       = (state == S_RUN);
  assign training     = (state == S_TRAIN);
  assign up.din_ready = run_st && boundary && up.tx_en;
  assign wordcnt_nx   = wordcnt + WC'(1);

  // Training has priority; in RUN the gap filler covers both a disabled
  // link and a missing word so the pad always carries a defined pattern.
  always_comb begin
    next_word = IDLE_PATTERN;
    if (!run_st)
      next_word = TRAIN_PATTERN;
    else if (up.tx_en && up.din_valid)
      next_word = up.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      wordcnt  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= boundary && run_st && up.tx_en && !up.din_valid;
      if (boundary && !run_st) begin
        wordcnt <= wordcnt_nx;
        if (wordcnt_nx == WC'(TRAIN_WORDS))
          state <= S_RUN;
      end
    end
  end

  lvds_tx_piso #(
    .WIDTH (WIDTH),
    .BW    (BW)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .next_word (next_word),
    .boundary  (boundary),
    .dout      (dout),
    .frame     (frame)
  );
endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Bench for lvds_tx_serializer: directed scenarios plus random traffic,
// checked against an edge-count model of the bit stream.
module tb_lvds_tx_serializer;
  localparam int W = 8;
  localparam logic [7:0] TRN = 8'hF0;
  localparam logic [7:0] IDL = 8'hBC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvds_tx_if #(.WIDTH(W)) bus0 ();
  lvds_tx_if #(.WIDTH(W)) bus1 ();
  logic dout0, frame0, und0, trn0;
  logic dout1, frame1, und1, trn1;

  lvds_tx_serializer #(.WIDTH(W), .TRAIN_WORDS(2), .TRAIN_PATTERN(TRN), .IDLE_PATTERN(IDL)) dut0 (
    .clk(clk), .rst(rst), .up(bus0), .dout(dout0), .frame(frame0), .underrun(und0), .training(trn0));
  lvds_tx_serializer #(.WIDTH(W), .TRAIN_WORDS(0), .TRAIN_PATTERN(TRN), .IDLE_PATTERN(IDL)) dut1 (
    .clk(clk), .rst(rst), .up(bus1), .dout(dout1), .frame(frame1), .underrun(und1), .training(trn1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: n = edges since the last reset edge; edge n is a boundary when
  // (n-1)%W==0, word k = (n-1)/W is training while k < TW.
  int         tw [2] = '{2, 0};
  int         n  [2];
  logic [7:0] word [2];
  bit         und_m [2];
  bit         mvalid = 0;

  function automatic bit m_train(int i);
    return ((n[i] + W - 1) / W) < tw[i];
  endfunction

  function automatic bit m_ready(int i, bit en);
    return !m_train(i) && (n[i] % W == 0) && en;
  endfunction

  function automatic bit m_dout(int i);
    if (n[i] == 0) return 1'b0;
    return word[i][W-1 - ((n[i]-1) % W)];
  endfunction

  function automatic bit m_frame(int i);
    return (n[i] != 0) && ((n[i]-1) % W == 0);
  endfunction

  task automatic m_edge(int i, bit r, bit en, bit v, logic [7:0] d);
    if (r) begin
      n[i] = 0; word[i] = '0; und_m[i] = 0;
    end else begin
      und_m[i] = 0;
      if (n[i] % W == 0) begin
        if (n[i] / W < tw[i]) word[i] = TRN;
        else if (en && v)     word[i] = d;
        else begin
          word[i] = IDL;
          und_m[i] = en;
        end
      end
      n[i]++;
    end
  endtask

  // One clock: drive on the falling edge, check ready before the rising
  // edge, advance the model, check registered outputs just after.
  task automatic step(input bit r, input bit en, input bit v, input logic [7:0] d, output bit acc);
    @(negedge clk);
    rst = r;
    bus0.tx_en = en; bus0.din_valid = v; bus0.din = d;
    bus1.tx_en = en; bus1.din_valid = v; bus1.din = d;
    #1;
    acc = mvalid && !r && m_ready(0, en) && v;
    if (mvalid) begin
      chk("ready0", bus0.din_ready, m_ready(0, en));
      chk("ready1", bus1.din_ready, m_ready(1, en));
    end
    @(posedge clk);
    m_edge(0, r, en, v, d);
    m_edge(1, r, en, v, d);
    if (r) mvalid = 1;
    #1;
    if (mvalid) begin
      chk("dout0",  dout0,  m_dout(0));
      chk("frame0", frame0, m_frame(0));
      chk("under0", und0,   und_m[0]);
      chk("train0", trn0,   m_train(0));
      chk("dout1",  dout1,  m_dout(1));
      chk("frame1", frame1, m_frame(1));
      chk("under1", und1,   und_m[1]);
      chk("train1", trn1,   m_train(1));
    end
  endtask

  task automatic idle_steps(input int cnt, input bit en, input bit v, input logic [7:0] d);
    bit a;
    for (int i = 0; i < cnt; i++) step(1'b0, en, v, d, a);
  endtask

  // Hold a word valid until the DUT takes it, bounded.
  task automatic send(input logic [7:0] d);
    bit a;
    for (int i = 0; i < 4*W; i++) begin
      step(1'b0, 1'b1, 1'b1, d, a);
      if (a) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit a;
    bit pend, en;
    logic [7:0] pd;
    bus0.tx_en = 1'b0; bus0.din_valid = 1'b0; bus0.din = '0;
    bus1.tx_en = 1'b0; bus1.din_valid = 1'b0; bus1.din = '0;

    // Reset, then the two training words.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h00, a);
    chk("rst_dout", dout0, 1'b0);
    chk("rst_train", trn0, 1'b1);
    chk("rst_train_tw0", trn1, 1'b0);
    idle_steps(16, 1'b1, 1'b0, 8'h00);

    // Back-to-back data, then an underrun gap, then a late word.
    send(8'hA5);
    send(8'h3C);
    idle_steps(8, 1'b1, 1'b0, 8'h00);
    send(8'h5A);

    // Link disabled mid-word while a word is offered.
    idle_steps(3, 1'b1, 1'b0, 8'h00);
    idle_steps(12, 1'b0, 1'b1, 8'h77);
    send(8'h77);

    // Reset part-way through a word, then retrain and resume.
    send(8'hA5);
    idle_steps(3, 1'b1, 1'b1, 8'hC3);
    step(1'b1, 1'b1, 1'b0, 8'h00, a);
    chk("midrst_dout", dout0, 1'b0);
    idle_steps(16, 1'b1, 1'b0, 8'h00);
    send(8'h3C);

    // Random traffic with occasional reset and enable changes.
    pend = 0; en = 1; pd = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) en = ~en;
      if (!pend && $urandom_range(2) != 0) begin
        pend = 1; pd = 8'($urandom);
      end
      step(($urandom_range(399) == 0), en, pend, pd, a);
      if (a) pend = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lvds_tx_serializer.md
# lvds_tx_serializer

Parallel-to-serial transmit stage that drives the single-ended input of the differential LVDS output buffer. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock. After reset it sends a training sequence; afterwards it fills every gap in the data stream with an idle pattern, so the pad never carries an undefined bit. It also emits a frame marker on the first bit of each word for downstream alignment logic.

## Interface
- WIDTH, 8: word width in bits; must be at least 2.
- TRAIN_WORDS, 4: number of training words sent after reset; 0 is legal and skips training.
- TRAIN_PATTERN, 8'hF0: WIDTH-bit training word.
- IDLE_PATTERN, 8'hBC: WIDTH-bit filler word.
- CLK  input  1  bit clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous and active-high; overrides every other input.
- TX_EN  input  1  when low, only idle words are sent and no data is accepted.
- DIN  input  WIDTH  parallel data word.
- DIN_VALID  input  1  DIN holds a word.
- DIN_READY  output  1  the stage takes DIN at the next edge if DIN_VALID is high.
- DOUT  output  1  serial bit that feeds the LVDS buffer input.
- FRAME  output  1  high while DOUT carries the MSB of a word.
- UNDERRUN  output  1  one-cycle pulse when an idle word is inserted during RUN with TX_EN high.
- TRAINING  output  1  high while the state is TRAIN.

## Operation
- Registers:
  - shreg[WIDTH-1:0]
  - bitcnt: $clog2(WIDTH) bits
  - wordcnt: $clog2(TRAIN_WORDS+1) bits
  - state: TRAIN or RUN
  - FRAME and UNDERRUN flops
- DOUT = shreg[WIDTH-1]. It is a register output with no combinational path from any input.
- Reset values:
  - shreg = 0, so DOUT = 0
  - bitcnt = WIDTH-1
  - wordcnt = 0
  - FRAME = 0, UNDERRUN = 0
  - state = TRAIN, or RUN when TRAIN_WORDS = 0
- Every edge with RST low is one of two kinds:
  - Boundary edge (bitcnt == WIDTH-1): load the next word into shreg, set bitcnt = 0, FRAME <= 1.
  - Shift edge (any other bitcnt): shreg <= {shreg[WIDTH-2:0], 1'b0}, bitcnt++, FRAME <= 0.
- Next-word selection at a boundary edge:
  - In TRAIN: load TRAIN_PATTERN and increment wordcnt. When the word just loaded is number TRAIN_WORDS, state moves to RUN on the same edge.
  - In RUN with TX_EN high and DIN_VALID high: load DIN.
  - In RUN with TX_EN high and DIN_VALID low: load IDLE_PATTERN and set UNDERRUN <= 1.
  - In RUN with TX_EN low: load IDLE_PATTERN; UNDERRUN stays 0.
- DIN_READY = (state == RUN) && (bitcnt == WIDTH-1) && TX_EN.
  - A transfer happens on the edge where DIN_READY and DIN_VALID are both high.
  - The upstream block must hold DIN and DIN_VALID until that edge.
- UNDERRUN clears on the edge after it is set.
- TRAINING = (state == TRAIN).
- Boundary conditions:
  - RST asserted mid-word: the word is truncated, DOUT = 0 after that edge, and training restarts.
  - TX_EN falling mid-word: the current word completes; the next boundary loads idle.
  - TX_EN rising: the first data word is accepted at the next boundary.
  - DIN_VALID high while DIN_READY is low: the word is not consumed, and there is no error.
  - RUN is never left except through RST.

## Timing
- Number edges from the first edge with RST low as edge 1.
- Edge 1 is a boundary edge; training word k is loaded at edge 1 + k*WIDTH.
- First DIN_READY is high in the cycle before edge TRAIN_WORDS*WIDTH + 1.
- Latency: a word accepted at edge t puts its MSB on DOUT right after edge t, with FRAME = 1 in the same cycle. Bit i (MSB = 0) appears after edge t + i.
- Throughput: one word per WIDTH cycles; back-to-back transfers have no gap bits.

## Structure
- Shared package lvds_tx_pkg holds:
  - the state enum (TRAIN, RUN)
  - default TRAIN_PATTERN and IDLE_PATTERN constants
  - the counter-width function
- Sub-module lvds_tx_piso: shift register, bit counter, boundary strobe and FRAME.
- The top level holds the FSM, word counter, handshake and UNDERRUN.

## Test plan
All scenarios use WIDTH=8, TRAIN_WORDS=2, TRAIN=F0, IDLE=BC.
- Reset: RST high for 3 cycles. Required: DOUT=0, FRAME=0, DIN_READY=0, TRAINING=1 throughout. After release, DOUT shows 11110000 twice, then DIN_READY=1 in the cycle before edge 17.
- Back-to-back: DIN=A5 then 3C, each held valid until accepted. Required: DOUT shows 10100101 then 00111100 with no gap bits, FRAME high on each MSB, UNDERRUN never high.
- Underrun: DIN_VALID low at edge 17. Required: DOUT shows 10111100 and UNDERRUN pulses for exactly one cycle. A word presented at edge 25 is sent next.
- TX_EN low at edge 20 while DIN_VALID is held high. Required: the current word completes, BC follows, DIN_READY stays 0, DIN is not consumed, UNDERRUN=0. Raising TX_EN accepts DIN at the next boundary.
- Reset mid-word: RST asserted at the 4th bit of A5. Required: DOUT=0 on the next edge; after release, two F0 training words are sent, then DIN_READY.
- TRAIN_WORDS=0 build: required TRAINING=0 after reset and DIN_READY=1 in the cycle before edge 1, so the first data word loads at edge 1.
